// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, registered instruction handshake,
// and redirect handling. Optional misaligned-target trap enabled by FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misalign
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {StIdle, StFetch, StDrop, StValid, StTrap} state_e;
`else
  typedef enum logic [2:0] {StIdle, StFetch, StDrop, StValid} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q;
  logic [31:0] instr_q, ipc_q;
  logic [31:0] target;
  logic        redir_take;
  logic        accept;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic bad_target;
  logic pend_q, pend_d;

  assign target     = redirect_pc;
  assign bad_target = redirect_valid && (redirect_pc[1:0] != 2'b00) && (state_q != StTrap);
  assign redir_take = redirect_valid && !bad_target && (state_q != StTrap);
`else
  logic unused_lsb;

  assign unused_lsb = ^redirect_pc[1:0];
  assign target     = {redirect_pc[31:2], 2'b00};
  assign redir_take = redirect_valid;
`endif

  // Response data is kept only when no redirect races it.
  assign accept = (state_q == StFetch) && imem_ack && !redirect_valid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: begin
        if (redirect_valid) begin
          state_d = imem_ack ? StFetch : StDrop;
        end else if (imem_ack) begin
          state_d = StValid;
        end
      end
      StDrop:  if (imem_ack) state_d = StFetch;
      StValid: if (redirect_valid || inst_ready) state_d = StFetch;
`ifdef FETCH_MISALIGN_TRAP_EN
      StTrap:  state_d = StTrap;
`endif
      default: state_d = StIdle;
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    if (bad_target) state_d = StTrap;
`endif
  end

  // Output logic
  always_comb begin
    imem_req   = (state_q == StFetch) || (state_q == StDrop);
    inst_valid = (state_q == StValid);
    misalign   = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (state_q == StTrap) begin
      imem_req = pend_q;
      misalign = 1'b1;
    end
`endif
  end

  assign imem_addr   = addr_q;
  assign Instruction = instr_q;
  assign inst_pc     = ipc_q;

  always_comb begin
    pc_d = pc_q;
    if (accept) pc_d = pc_q + 32'd4;
    if (redir_take) pc_d = target;
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // A request already on the bus when trapping is held until its ack, then dropped.
  always_comb begin
    pend_d = pend_q;
    if (bad_target) begin
      pend_d = ((state_q == StFetch) || (state_q == StDrop)) && !imem_ack;
    end else if ((state_q == StTrap) && imem_ack) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      instr_q <= 32'h0000_0013;
      ipc_q   <= 32'h0000_0000;
    end else begin
      pc_q <= pc_d;
      // The request address only moves when a new request starts.
      if (state_d == StFetch) addr_q <= pc_d;
      if (accept) begin
        instr_q <= imem_rdata;
        ipc_q   <= pc_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory responder with programmable ack delay,
// scoreboard of expected (pc, instruction) transfers, and inline output checks.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] Instruction;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          ack_delay = 0;
  int          cnt = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] held_instr, held_pc;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .Instruction   (Instruction),
    .inst_pc       (inst_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .misalign      (misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w(input logic [31:0] a);
    return a + 32'h0BAD_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample point: 2 time units after the falling edge.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.data = w(pc);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    rst       = 1'b1;
    ack_delay = 0;
    tick();
    tick();
  endtask

  // Memory responder: acks the held request after ack_delay idle cycles.
  always begin
    @(negedge clk);
    #1;
    if (imem_req && cnt >= ack_delay) begin
      imem_ack   = 1'b1;
      imem_rdata = w(imem_addr);
      cnt        = 0;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      cnt        = imem_req ? cnt + 1 : 0;
    end
  end

  // Transfer monitor: pops the scoreboard and checks held outputs stay stable.
  always begin
    exp_t e;
    @(negedge clk);
    #4;
    if (hold_prev && inst_valid) begin
      chk("hold_instr", Instruction, held_instr);
      chk("hold_pc", inst_pc, held_pc);
    end
    if (inst_valid && inst_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("xfer_pc", inst_pc, e.pc);
        chk("xfer_instr", Instruction, e.data);
      end
    end
    hold_prev  = inst_valid && !inst_ready && !redirect_valid && !rst;
    held_instr = Instruction;
    held_pc    = inst_pc;
  end

  initial begin
    rst            = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    tick();
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_instr", Instruction, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_misalign", misalign, 1'b0);

    // Zero-wait sequential fetch, one instruction per two cycles.
    push(32'h0); push(32'h4); push(32'h8);
    inst_ready = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("seq_req", imem_req, 1'b1);
      chk("seq_addr", imem_addr, 32'(4 * i));
      chk("seq_novalid", inst_valid, 1'b0);
      tick();
      chk("seq_valid", inst_valid, 1'b1);
      chk("seq_inst_pc", inst_pc, 32'(4 * i));
      chk("seq_noreq", imem_req, 1'b0);
    end
    tick();
    do_reset();

    // Two-cycle ack delay, downstream stalled for three cycles.
    push(32'h0);
    ack_delay = 2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("slow_req", imem_req, 1'b1);
      chk("slow_addr", imem_addr, 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", inst_valid, 1'b1);
      chk("stall_instr", Instruction, w(32'h0));
      chk("stall_noreq", imem_req, 1'b0);
    end
    tick();
    inst_ready = 1'b1;
    tick();
    chk("after_xfer_req", imem_req, 1'b1);
    chk("after_xfer_addr", imem_addr, 32'h4);
    do_reset();

    // Redirect while the fetch of 0x8 is pending.
    push(32'h0); push(32'h4); push(32'h100);
    inst_ready = 1'b1;
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    chk("pre_redir_pc", inst_pc, 32'h4);
    ack_delay = 2;
    tick();
    chk("pend_addr", imem_addr, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("drop_req", imem_req, 1'b1);
    chk("drop_addr", imem_addr, 32'h8);
    tick();
    chk("drop_addr2", imem_addr, 32'h8);
    chk("drop_novalid", inst_valid, 1'b0);
    tick();
    chk("refetch_addr", imem_addr, 32'h100);
    chk("refetch_novalid", inst_valid, 1'b0);
    tick(); tick(); tick();
    chk("redir_valid", inst_valid, 1'b1);
    chk("redir_inst_pc", inst_pc, 32'h100);
    tick();
    do_reset();

    // Redirect coinciding with ack, then redirect while holding a valid instruction.
    rst = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("ackredir_addr", imem_addr, 32'h40);
    chk("ackredir_novalid", inst_valid, 1'b0);
    tick();
    chk("v40_pc", inst_pc, 32'h40);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick();
    redirect_valid = 1'b0;
    chk("vredir_novalid", inst_valid, 1'b0);
    chk("vredir_addr", imem_addr, 32'h80);
    tick();
    push(32'h80);
    inst_ready = 1'b1;
    tick();
    chk("post80_addr", imem_addr, 32'h84);
    do_reset();

    // PC wrap at the top of the address space.
    push(32'hFFFF_FFFC); push(32'h0);
    inst_ready = 1'b1;
    rst = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("top_inst_pc", inst_pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr", imem_addr, 32'h0);
    tick();
    chk("wrap_inst_pc", inst_pc, 32'h0);
    tick();
    do_reset();

    // Misaligned redirect target.
    rst = 1'b0;
`ifndef FETCH_MISALIGN_TRAP_EN
    push(32'h100);
    inst_ready = 1'b1;
`endif
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    tick();
`ifdef FETCH_MISALIGN_TRAP_EN
    redirect_pc = 32'h200;
    for (int i = 0; i < 4; i++) begin
      chk("trap_misalign", misalign, 1'b1);
      chk("trap_noreq", imem_req, 1'b0);
      chk("trap_novalid", inst_valid, 1'b0);
      tick();
    end
    redirect_valid = 1'b0;
`else
    redirect_valid = 1'b0;
    chk("mis_addr", imem_addr, 32'h100);
    chk("mis_flag", misalign, 1'b0);
    tick();
    chk("mis_inst_pc", inst_pc, 32'h100);
    tick();
`endif
    do_reset();
    chk("final_misalign", misalign, 1'b0);
    chk("final_valid", inst_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
